fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the main decoder/control unit.
- Holds the PC and issues in-order word requests to instruction memory.
- Buffers returned instructions and presents them, with their PC and extracted opcode[6:0], to decode over a valid/ready handshake.
- Takes branch redirects from execute and discards stale in-flight responses.

---
 rtl/riscv_defs.sv | 16 +
 rtl/fetch_buffer.sv | 63 ++++++
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defs.sv
// Shared RISC-V definitions: opcodes, instruction width, fetch FSM codes.
// Imported by the fetch stage and by anything decoding its output.
package riscv_defs;

  localparam int INST_W = 32;

  localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
  localparam logic [6:0] OPC_LD     = 7'b0000011;
  localparam logic [6:0] OPC_SD     = 7'b0100011;
  localparam logic [6:0] OPC_BEQ    = 7'b1100011;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO, DEPTH x WIDTH: push/pop/flush in, full/empty/count out.
// rdata is the head entry; a pop on a full FIFO may coincide with a push.
module fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    if (p == AW'(DEPTH - 1)) return '0;
    return p + AW'(1);
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      if (do_push && !do_pop)
        cnt <= cnt + CW'(1);
      else if (do_pop && !do_push)
        cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, imem request/response, instruction buffer to decode,
// branch redirect with stale-response drain, halt; fetch_state for debug.
module fetch_unit
  import riscv_defs::*;
#(
  parameter int              PC_W      = 64,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [PC_W-1:0]   inst_pc,
  output logic [6:0]        opcode,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  input  logic              halt,
  output logic [1:0]        fetch_state
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int EW = INST_W + PC_W;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);

  logic [PC_W-1:0] pc;
  logic [1:0]      state;
  logic [1:0]      state_n;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   discard_n;
  logic [CW:0]     in_flight;

  logic            redirect;
  logic            fire;
  logic            rsp_accept;
  logic            pop;

  logic [EW-1:0]   head;
  logic [CW-1:0]   buf_count;
  logic            buf_full;
  logic            buf_empty;
  logic [PC_W-1:0] rsp_pc;
  logic [CW-1:0]   pcq_count;
  logic            pcq_full;
  logic            pcq_empty;
  logic            unused_sig;

  assign unused_sig = ^{buf_full, pcq_full, pcq_empty,
                        pcq_count, branch_target[1:0]};

  assign redirect = branch_taken & ~halt & ~reset
                  & (state != ST_HALT);

  assign in_flight = {1'b0, outstanding}
                   + {1'b0, buf_count};

  // Slots are reserved at issue, so a response
  // always finds room in the buffer.
  assign imem_req_valid = ~reset & (state == ST_RUN)
                        & (in_flight < DEPTH_C)
                        & ~branch_taken & ~halt;
  assign imem_req_addr  = pc;
  assign fire = imem_req_valid & imem_req_ready;

  // Non-zero discard marks responses as stale.
  assign rsp_accept = imem_rsp_valid & ~redirect
                    & (discard == '0);

  assign inst_valid = ~reset & ~buf_empty & ~redirect;
  assign pop        = inst_valid & inst_ready;
  assign inst_data  = buf_empty ? '0 : head[EW-1:PC_W];
  assign inst_pc    = buf_empty ? '0 : head[PC_W-1:0];
  assign opcode     = inst_data[6:0];
  assign fetch_state = state;

  always_comb begin
    state_n   = state;
    discard_n = discard;
    if (state == ST_RUN && redirect)
      discard_n = outstanding
                - CW'(imem_rsp_valid);
    else if (imem_rsp_valid && discard != '0)
      discard_n = discard - CW'(1);
    if (state != ST_HALT) begin
      if (halt)
        state_n = ST_HALT;
      else if (state == ST_RUN && redirect)
        state_n = (discard_n != '0) ? ST_DRAIN
                                    : ST_RUN;
      else if (state == ST_DRAIN && imem_rsp_valid
               && discard == CW'(1))
        state_n = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= {RESET_PC[PC_W-1:2], 2'b00};
      state       <= ST_RUN;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state   <= state_n;
      discard <= discard_n;
      if (redirect)
        pc <= {branch_target[PC_W-1:2], 2'b00};
      else if (fire)
        pc <= pc + PC_W'(4);
      if (fire && !imem_rsp_valid)
        outstanding <= outstanding + CW'(1);
      else if (!fire && imem_rsp_valid)
        outstanding <= outstanding - CW'(1);
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (EW)
  ) u_ibuf (
    .clk   (clk),
    .reset (reset),
    .push  (rsp_accept),
    .pop   (pop),
    .flush (redirect),
    .wdata ({imem_rsp_data, rsp_pc}),
    .rdata (head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  // PCs of requests in flight, in issue order.
  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (PC_W)
  ) u_pcq (
    .clk   (clk),
    .reset (reset),
    .push  (fire),
    .pop   (rsp_accept),
    .flush (redirect),
    .wdata (pc),
    .rdata (rsp_pc),
    .full  (pcq_full),
    .empty (pcq_empty),
    .count (pcq_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-model memory, PC scoreboard,
// redirect/drain, wrap and halt scenarios.
module tb_fetch_unit;
  import riscv_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        halt;
  logic [1:0]  fetch_state;

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_W      (64),
    .RESET_PC  (64'h0),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .opcode         (opcode),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .halt           (halt),
    .fetch_state    (fetch_state)
  );

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] fired[$];
  logic [63:0] popped[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [63:0] exp_pc;
  bit          halted;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [6:0] t;
    case (a[3:2])
      2'd0:    t = OPC_R_TYPE;
      2'd1:    t = OPC_LD;
      2'd2:    t = OPC_SD;
      default: t = OPC_BEQ;
    endcase
    return {a[26:2], t};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic        fire;
    logic        pop;
    logic        redir;
    logic [63:0] p;
    logic [31:0] w;
    if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    fire  = imem_req_valid & imem_req_ready;
    pop   = inst_valid & inst_ready;
    redir = branch_taken & ~halt & ~halted;
    if (redir)  chk("req_on_redirect", imem_req_valid, 0);
    if (halted) chk("req_while_halted", imem_req_valid, 0);
    if (fire) begin
      chk("req_addr", imem_req_addr, exp_pc);
      fired.push_back(imem_req_addr);
      exp_q.push_back(exp_pc);
      mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
      exp_pc = exp_pc + 64'd4;
    end
    if (pop) begin
      chk("pop_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        p = exp_q.pop_front();
        w = mem_word(p);
        chk("inst_pc", inst_pc, p);
        chk("inst_data", inst_data, w);
        chk("opcode", opcode, w[6:0]);
        popped.push_back(inst_pc);
      end
    end
    if (imem_rsp_valid) begin
      chk("rsp_outstanding", dut.outstanding != 0, 1);
      mem_q.delete(0);
    end
    chk("occupancy_bound",
        (int'(dut.outstanding) + int'(dut.buf_count)) <= 2, 1);
    if (redir) begin
      exp_q.delete();
      exp_pc = {branch_target[63:2], 2'b00};
    end
    if (halt) halted = 1'b1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    inst_ready     = 1'b1;
    branch_taken   = 1'b0;
    branch_target  = 64'h0;
    halt           = 1'b0;
    mem_q.delete();
    exp_q.delete();
    fired.delete();
    popped.delete();
    halted = 1'b0;
    exp_pc = 64'h0;
    lat    = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_state", fetch_state, ST_RUN);
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    int          first;
    logic [63:0] first_pc;
    logic [6:0]  first_opc;
    int          pend;

    // Streaming with 1-cycle memory.
    do_reset();
    first = -1;
    first_pc = '1;
    first_opc = '1;
    for (int i = 0; i < 20; i++) begin
      if (first < 0 && inst_valid) begin
        first = cyc;
        first_pc = inst_pc;
        first_opc = opcode;
      end
      tick();
    end
    chk("first_valid_cycle", first, 2);
    chk("first_pc", first_pc, 64'h0);
    chk("first_opcode", first_opc, 7'b0110011);
    chk("stream_fires", fired.size() >= 3, 1);
    chk("fire0", fired[0], 64'h0);
    chk("fire1", fired[1], 64'h4);
    chk("fire2", fired[2], 64'h8);

    // Decode stall: requests capped at the buffer depth.
    do_reset();
    inst_ready = 1'b0;
    repeat (10) tick();
    chk("stall_fires", fired.size(), 2);
    chk("stall_req_valid", imem_req_valid, 0);
    chk("stall_pops", popped.size(), 0);
    inst_ready = 1'b1;
    repeat (6) tick();
    chk("stall_delivered", popped.size() >= 2, 1);
    chk("stall_pop0", popped[0], 64'h0);
    chk("stall_pop1", popped[1], 64'h4);

    // Redirect with two stale responses in flight.
    do_reset();
    lat = 3;
    tick();
    tick();
    chk("pre_br_fires", fired.size(), 2);
    chk("pre_br_req_valid", imem_req_valid, 0);
    branch_taken  = 1'b1;
    branch_target = 64'h103;
    tick();
    branch_taken = 1'b0;
    chk("drain_state", fetch_state, ST_DRAIN);
    chk("drain_discard", dut.discard, 2);
    tick();
    tick();
    chk("drain_exit", fetch_state, ST_RUN);
    for (int i = 0; i < 30 && popped.size() == 0; i++) tick();
    chk("br_delivered", popped.size() > 0, 1);
    chk("br_first_pc", popped[0], 64'h100);
    chk("br_first_req", fired[2], 64'h100);

    // Redirect coinciding with a response and a pop.
    do_reset();
    tick();
    tick();
    chk("pre_rd_valid", inst_valid, 1);
    chk("pre_rd_rsp_due", mem_q.size() > 0 && mem_q[0].due == cyc, 1);
    pend = mem_q.size();
    branch_taken  = 1'b1;
    branch_target = 64'h200;
    tick();
    branch_taken = 1'b0;
    chk("rd_inst_valid", inst_valid, 0);
    chk("rd_buf_empty", dut.buf_count, 0);
    chk("rd_discard", dut.discard, pend - 1);
    chk("rd_state", fetch_state, ST_RUN);
    chk("rd_no_pop", popped.size(), 0);
    for (int i = 0; i < 20 && popped.size() == 0; i++) tick();
    chk("rd_delivered", popped.size() > 0, 1);
    chk("rd_first_pc", popped[0], 64'h200);

    // PC wrap at the top of the address space.
    do_reset();
    branch_taken  = 1'b1;
    branch_target = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    branch_taken = 1'b0;
    repeat (10) tick();
    chk("wrap_fires", fired.size() >= 2, 1);
    chk("wrap_fire0", fired[0], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_fire1", fired[1], 64'h0);
    chk("wrap_pops", popped.size() >= 2, 1);
    chk("wrap_pop0", popped[0], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_pop1", popped[1], 64'h0);

    // Halt with one request outstanding.
    do_reset();
    lat = 3;
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt_state", fetch_state, ST_HALT);
    repeat (4) tick();
    chk("halt_pops", popped.size(), 1);
    chk("halt_pop0", popped[0], 64'h0);
    chk("halt_fires", fired.size(), 1);
    branch_taken  = 1'b1;
    branch_target = 64'h300;
    tick();
    branch_taken = 1'b0;
    repeat (3) tick();
    chk("halt_br_state", fetch_state, ST_HALT);
    chk("halt_br_fires", fired.size(), 1);
    chk("halt_req_valid", imem_req_valid, 0);
    do_reset();
    tick();
    chk("post_halt_fires", fired.size(), 1);
    chk("post_halt_addr", fired[0], 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
